// File: rtl/unfifo_rd_framer.sv
// Pops words from a first-word fall-through FIFO, frames them and appends a checksum beat.
// Latency: a popped word appears on m_data_o one cycle after its rinc_o strobe.
// Backpressure: one registered output slot; no pop and no checksum load while the slot is held.
module unfifo_rd_framer #(
  parameter int DSIZE     = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic             rclk,
  input  logic             rrst_n_i,
  input  logic             enable_i,
  input  logic             rempty_i,
  input  logic [DSIZE-1:0] rdata_i,
  output logic             rinc_o,
  output logic             m_valid_o,
  output logic [DSIZE-1:0] m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic [15:0]      frame_cnt_o
);

  typedef enum logic [1:0] {IDLE, DATA, CSUM} state_t;

  // Index of the final data word in a frame; word_cnt is 16 bits wide.
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [DSIZE-1:0] csum_q, csum_d;
  logic [DSIZE-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic slot_free;
  logic pop;
  logic load_csum;

  // The output slot can take a new beat when empty or draining this cycle.
  assign slot_free = !m_valid_q || m_ready_i;
  assign pop       = (state_q == DATA) && !rempty_i && slot_free;
  assign load_csum = (state_q == CSUM) && slot_free;

  // State register.
  always_ff @(posedge rclk or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enable_i only matters in IDLE and when leaving CSUM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = DATA;
      DATA:    if (pop && (word_cnt_q == LAST_IDX)) state_d = CSUM;
      CSUM:    if (slot_free) state_d = enable_i ? DATA : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath: load a data word on pop, the checksum on CSUM exit.
  always_comb begin
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;
    csum_d      = csum_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (m_valid_q && m_ready_i) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        csum_d     = '0;
      end
      DATA: begin
        if (pop) begin
          m_data_d   = rdata_i;
          m_last_d   = 1'b0;
          m_valid_d  = 1'b1;
          csum_d     = csum_q + rdata_i;
          word_cnt_d = word_cnt_q + 16'd1;
        end
      end
      CSUM: begin
        if (load_csum) begin
          m_data_d    = csum_q;
          m_last_d    = 1'b1;
          m_valid_d   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          word_cnt_d  = '0;
          csum_d      = '0;
        end
      end
      default: begin
        word_cnt_d = '0;
        csum_d     = '0;
      end
    endcase
  end

  // Datapath registers; a reset mid-frame drops the partial frame.
  always_ff @(posedge rclk or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      csum_q      <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      csum_q      <= csum_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rinc_o      = pop;
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign m_last_o    = m_last_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_unfifo_rd_framer.sv
// Bench for unfifo_rd_framer: FIFO model as a queue, expected beats from frame rules.
// Inputs driven at the falling edge, outputs sampled 1 time unit later.
// Downstream ready is fixed or randomized; the scoreboard checks order, stalls and pop legality.
module tb_unfifo_rd_framer;

  localparam int FLEN = 8;

  logic        rclk = 1'b0;
  logic        rrst_n_i;
  logic        enable_i;
  logic        rempty_i;
  logic [15:0] rdata_i;
  logic        rinc_o;
  logic        m_valid_o;
  logic [15:0] m_data_o;
  logic        m_last_o;
  logic        m_ready_i;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  unfifo_rd_framer #(.DSIZE(16), .FRAME_LEN(FLEN)) u_dut (
    .rclk        (rclk),
    .rrst_n_i    (rrst_n_i),
    .enable_i    (enable_i),
    .rempty_i    (rempty_i),
    .rdata_i     (rdata_i),
    .rinc_o      (rinc_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i),
    .frame_cnt_o (frame_cnt_o)
  );

  // FIFO contents, words not yet arrived, and expected beats {last, data}
  logic [15:0] fifo_q[$];
  logic [15:0] src_q[$];
  logic [16:0] exp_q[$];
  logic [15:0] w [FLEN];

  bit          force_empty = 0;
  bit          rand_ready  = 0;
  bit          rand_feed   = 0;
  bit          pop_now     = 0;
  bit          prev_stall  = 0;
  logic [15:0] prev_data   = '0;
  logic        prev_last   = 1'b0;
  logic [15:0] last_csum   = '0;
  int          pops        = 0;
  int          exp_frames  = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        r;
    logic [15:0] f;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected beats of one frame: the words, then their sum mod 2^16 flagged last.
  task automatic push_exp();
    int s = 0;
    for (int i = 0; i < FLEN; i++) begin
      exp_q.push_back({1'b0, w[i]});
      s += int'(w[i]);
    end
    exp_q.push_back({1'b1, 16'(s)});
    exp_frames++;
  endtask

  task automatic settle();
    logic [16:0] e;
    if (rand_feed && src_q.size() != 0 && $urandom_range(0, 1) == 1)
      fifo_q.push_back(src_q.pop_front());
    if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
    rempty_i = force_empty || (fifo_q.size() == 0);
    rdata_i  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
    #1;
    if (rinc_o) check("rinc_when_empty", 32'(rempty_i), 0);
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid_o), 1);
      check("stall_data", 32'(m_data_o), 32'(prev_data));
      check("stall_last", 32'(m_last_o), 32'(prev_last));
    end
    if (m_valid_o && !m_ready_i) check("rinc_while_stalled", 32'(rinc_o), 0);
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got 0x%0h, required no beat", {m_last_o, m_data_o});
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({m_last_o, m_data_o}), 32'(e));
      end
      if (m_last_o) last_csum = m_data_o;
    end
    prev_stall = m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    pop_now    = rinc_o;
  endtask

  task automatic advance();
    @(posedge rclk);
    if (pop_now && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    @(negedge rclk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic run_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_o) && n < budget) begin
      step();
      n++;
    end
    check({name, "_beats_left"}, 32'(exp_q.size()), 0);
    check({name, "_frame_cnt"}, 32'(frame_cnt_o), 32'(exp_frames));
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pops < target && n < 100) begin
      step();
      n++;
    end
    check("wait_pops", 32'(pops), 32'(target));
  endtask

  initial begin
    rrst_n_i  = 1'b0;
    enable_i  = 1'b0;
    m_ready_i = 1'b0;
    rempty_i  = 1'b1;
    rdata_i   = '0;
    @(negedge rclk);
    @(negedge rclk);
    #1;
    check("rst_valid", 32'(m_valid_o), 0);
    check("rst_data", 32'(m_data_o), 0);
    check("rst_last", 32'(m_last_o), 0);
    check("rst_frame_cnt", 32'(frame_cnt_o), 0);
    check("rst_rinc", 32'(rinc_o), 0);
    @(negedge rclk);
    rrst_n_i = 1'b1;

    // Cycle table: FIFO holds 1..8, ready high, enable dropped before the checksum exit
    for (int i = 0; i < 12; i++) begin
      tbl[i].en  = (i < 9);
      tbl[i].rdy = 1'b1;
      tbl[i].v   = (i >= 2 && i <= 10);
      tbl[i].d   = (i == 10) ? 16'h0024 : 16'(i - 1);
      tbl[i].l   = (i == 10);
      tbl[i].r   = (i >= 1 && i <= 8);
      tbl[i].f   = (i >= 10) ? 16'd1 : 16'd0;
    end
    for (int i = 0; i < FLEN; i++) begin
      w[i] = 16'(i + 1);
      fifo_q.push_back(w[i]);
    end
    push_exp();
    for (int i = 0; i < 12; i++) begin
      enable_i  = tbl[i].en;
      m_ready_i = tbl[i].rdy;
      settle();
      check($sformatf("tbl%0d_valid", i), 32'(m_valid_o), 32'(tbl[i].v));
      check($sformatf("tbl%0d_rinc", i), 32'(rinc_o), 32'(tbl[i].r));
      check($sformatf("tbl%0d_frame_cnt", i), 32'(frame_cnt_o), 32'(tbl[i].f));
      if (tbl[i].v) begin
        check($sformatf("tbl%0d_data", i), 32'(m_data_o), 32'(tbl[i].d));
        check($sformatf("tbl%0d_last", i), 32'(m_last_o), 32'(tbl[i].l));
      end
      advance();
    end
    check("tbl_beats_left", 32'(exp_q.size()), 0);

    // Same data with random downstream backpressure
    for (int i = 0; i < FLEN; i++) fifo_q.push_back(16'(i + 1));
    push_exp();
    enable_i   = 1'b1;
    rand_ready = 1;
    run_done("rand_ready", 400);
    rand_ready = 0;
    m_ready_i  = 1'b1;

    // Checksum wrap-around
    for (int i = 0; i < FLEN; i++) begin
      w[i] = 16'hFFFF;
      fifo_q.push_back(w[i]);
    end
    push_exp();
    run_done("wrap", 100);
    check("wrap_csum", 32'(last_csum), 32'h0000_FFF8);

    // FIFO empty for 5 cycles after word 3
    for (int i = 0; i < FLEN; i++) begin
      w[i] = 16'h0A00 + 16'(i);
      fifo_q.push_back(w[i]);
    end
    push_exp();
    pops = 0;
    wait_pops(3);
    force_empty = 1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("gap_rinc", 32'(rinc_o), 0);
      if (k > 0) check("gap_no_beat", 32'(m_valid_o), 0);
      advance();
    end
    force_empty = 0;
    run_done("gap", 100);

    // enable dropped after word 2: frame completes, then stays idle
    for (int i = 0; i < FLEN; i++) begin
      w[i] = 16'h0100 + 16'(i);
      fifo_q.push_back(w[i]);
    end
    push_exp();
    for (int i = 0; i < FLEN; i++) fifo_q.push_back(16'h0200 + 16'(i));
    pops = 0;
    wait_pops(2);
    enable_i = 1'b0;
    run_done("en_drop", 100);
    for (int k = 0; k < 10; k++) begin
      settle();
      check("idle_rinc", 32'(rinc_o), 0);
      check("idle_valid", 32'(m_valid_o), 0);
      advance();
    end
    for (int i = 0; i < FLEN; i++) w[i] = 16'h0200 + 16'(i);
    push_exp();
    enable_i = 1'b1;
    run_done("en_resume", 100);

    // Random data trickling into the FIFO, random ready
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < FLEN; i++) begin
        w[i] = 16'($urandom);
        src_q.push_back(w[i]);
      end
      push_exp();
    end
    rand_ready = 1;
    rand_feed  = 1;
    run_done("random", 2000);
    rand_ready = 0;
    rand_feed  = 0;
    m_ready_i  = 1'b1;

    // Reset in the middle of a frame
    for (int i = 0; i < FLEN; i++) begin
      w[i] = 16'h0300 + 16'(i);
      fifo_q.push_back(w[i]);
    end
    push_exp();
    pops = 0;
    wait_pops(3);
    #2;
    rrst_n_i = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid_o), 0);
    check("midrst_data", 32'(m_data_o), 0);
    check("midrst_last", 32'(m_last_o), 0);
    check("midrst_frame_cnt", 32'(frame_cnt_o), 0);
    check("midrst_rinc", 32'(rinc_o), 0);
    fifo_q.delete();
    exp_q.delete();
    prev_stall = 0;
    exp_frames = 0;
    @(negedge rclk);
    rrst_n_i = 1'b1;
    for (int i = 0; i < FLEN; i++) begin
      w[i] = 16'h0400 + 16'(i);
      fifo_q.push_back(w[i]);
    end
    push_exp();
    run_done("post_rst", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
